// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline-stage registers.
//   skid_state_t : occupancy state of a skid-buffered stage
//   RstEnable    : asserted level of rst
//   ZeroWord     : all-zero RegBus word, default payload reset value
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one storage entry of a skid-buffered stage.
// Holds payload and sideband concatenated as a single W-bit word.
//   clk, rst : clock, async active-high reset (loads RST_VAL)
//   load     : capture d on the next rising edge
//   d, q     : slot input / registered contents
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int           W       = 33,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) q <= RST_VAL;
    else if (load)        q <= d;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: parametrised valid/ready pipeline register with a
// 2-entry skid buffer so in_ready comes straight from a flop.
//   clk, rst            : clock, async active-high reset
//   flush               : synchronous squash, stage empties next cycle
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_data/in_ctrl     : upstream payload / sideband
//   out_valid/out_ready : downstream handshake
//   out_data/out_ctrl   : presented beat, always from the main slot
//   occupancy           : entries held (0..2)
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 1,
  parameter logic [DATA_W-1:0] DATA_RST = DATA_W'(ZeroWord),
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int SW = DATA_W + CTRL_W;

  skid_state_t state_q, state_d;
  logic          main_load, skid_load, main_from_skid;
  logic [SW-1:0] in_word, main_d, main_q, skid_q;

  assign in_word = {in_ctrl, in_data};
  // In FULL the skid entry is the only source for main; refill from it.
  assign main_d  = main_from_skid ? skid_q : in_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state_q <= SKID_EMPTY;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_valid) begin
          main_load = 1'b1;
          state_d   = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_valid && out_ready) begin
          main_load = 1'b1;
        end else if (in_valid) begin
          skid_load = 1'b1;
          state_d   = SKID_FULL;
        end else if (out_ready) begin
          state_d   = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so in_valid cannot transfer.
        if (out_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = SKID_BUSY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Squash: drop any incoming beat, leave slot contents untouched
    // (they are invisible once out_valid falls).
    if (flush) begin
      state_d   = SKID_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      SKID_BUSY: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      SKID_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  pipe_skid_slot #(
    .W       (SW),
    .RST_VAL ({CTRL_RST, DATA_RST})
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_skid_slot #(
    .W       (SW),
    .RST_VAL ({CTRL_RST, DATA_RST})
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_word),
    .q    (skid_q)
  );

  assign out_data = main_q[DATA_W-1:0];
  assign out_ctrl = main_q[SW-1:DATA_W];

  // A presented beat must not change until it is taken.
  a_out_stable: assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_ctrl))
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int              DW    = 64;
  localparam int              CW    = 3;
  localparam logic [CW-1:0]   CRST  = 3'b101;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .DATA_RST ('0),
    .CTRL_RST (CRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD_BEEF;
    in_ctrl = 3'd2; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (out_ctrl !== CRST) begin errors++; $display("FAIL rst_out_ctrl got=%b exp=%b", out_ctrl, CRST); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hDEAD_BEEF || out_ctrl !== 3'd2)
      begin errors++; $display("FAIL rst_first_beat got v=%b d=%h c=%b exp v=1 d=deadbeef c=2", out_valid, out_data, out_ctrl); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i))
        begin errors++; $display("FAIL stream_beat%0d got v=%b d=%h c=%0d exp v=1 d=%0d", i, out_valid, out_data, out_ctrl, i); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
        begin errors++; $display("FAIL stream_occ%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 3'd1;
    step();
    in_data = 64'h22; in_ctrl = 3'd2;
    step();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0)
      begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
    in_data = 64'h33; in_ctrl = 3'd3;
    step();
    checks++; if (occupancy !== 2'd2 || out_data !== 64'h11)
      begin errors++; $display("FAIL bp_hold got occ=%0d d=%h exp occ=2 d=11", occupancy, out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'h11)
      begin errors++; $display("FAIL bp_out_a got rdy=%b v=%b d=%h exp rdy=0 v=1 d=11", in_ready, out_valid, out_data); end
    step();
    checks++; if (out_data !== 64'h22 || out_ctrl !== 3'd2 || occupancy !== 2'd1)
      begin errors++; $display("FAIL bp_out_b got d=%h occ=%0d exp d=22 occ=1", out_data, occupancy); end
    step();
    checks++; if (out_data !== 64'h33 || out_ctrl !== 3'd3 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_out_c got d=%h v=%b exp d=33 v=1", out_data, out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h61; step();
    in_data = 64'h62; step();
    in_data = 64'h44; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_full got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0)
        begin errors++; $display("FAIL flush_leak got v=%b d=%h exp v=0", out_valid, out_data); end
    end
    // Flush in BUSY with a same-cycle beat: the beat is discarded.
    in_valid = 1'b1; in_data = 64'h45; step();
    in_data = 64'h46; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin errors++; $display("FAIL flush_busy got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_async_rst();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h71; step();
    in_data = 64'h72; step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_pre got occ=%0d exp=2", occupancy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0)
      begin errors++; $display("FAIL arst_ctl got v=%b rdy=%b occ=%0d exp v=0 rdy=1 occ=0", out_valid, in_ready, occupancy); end
    checks++; if (out_data !== 64'h0 || out_ctrl !== CRST)
      begin errors++; $display("FAIL arst_data got d=%h c=%b exp d=0 c=%b", out_data, out_ctrl, CRST); end
    step();
    rst = 1'b0; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 3'd4; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 64'h55 || out_ctrl !== 3'd4)
      begin errors++; $display("FAIL arst_fresh got v=%b d=%h exp v=1 d=55", out_valid, out_data); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [DW+CW-1:0] q[$];
    logic [DW+CW-1:0] exp_w;
    logic r0;
    int drain;
    for (int c = 0; c < 10000; c++) begin
      r0 = in_ready;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = CW'($urandom_range(7));
      #1;
      checks++; if (in_ready !== r0)
        begin errors++; $display("FAIL rnd_ready_comb cyc=%0d got=%b exp=%b", c, in_ready, r0); end
      #1;
      if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_dup cyc=%0d got d=%h exp none", c, out_data); end
        else begin
          exp_w = q.pop_front();
          if ({out_ctrl, out_data} !== exp_w)
            begin errors++; $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c, {out_ctrl, out_data}, exp_w); end
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain = 0;
    while (out_valid && drain < 10) begin
      #1;
      checks++;
      if (q.size() == 0) begin errors++; $display("FAIL rnd_drain_dup got d=%h exp none", out_data); end
      else begin
        exp_w = q.pop_front();
        if ({out_ctrl, out_data} !== exp_w)
          begin errors++; $display("FAIL rnd_drain got=%h exp=%h", {out_ctrl, out_data}, exp_w); end
      end
      step();
      drain++;
    end
    checks++; if (q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rnd_loss got left=%0d v=%b exp left=0 v=0", q.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_async_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
